// File: rtl/exe_mul_seq_pkg.sv
// Shared execute-stage opcode definitions and multiply-sequencer constants.
// The operation codes match the decoder output encoding used across the EX stage.
package exe_mul_seq_pkg;

    localparam logic [4:0] I_ADD  = 5'd0;
    localparam logic [4:0] I_MUL  = 5'd10;
    localparam logic [4:0] I_MULH = 5'd11;

    localparam int EXE_MUL_ITER = 32;

    function automatic logic is_mul_op(input logic [4:0] op);
        return (op == I_MUL) || (op == I_MULH);
    endfunction

endpackage

// File: rtl/exe_mul_seq_if.sv
// EX-stage request/response bundle between the pipeline and the multiply sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface exe_mul_seq_if #(
    parameter int XLEN = 32
);
    logic [4:0]      optype;
    logic            op_valid;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            res_valid;
    logic [XLEN-1:0] res;

    modport master (
        output optype, op_valid, data1, data2, flush,
        input  stall, busy, res_valid, res
    );

    modport slave (
        input  optype, op_valid, data1, data2, flush,
        output stall, busy, res_valid, res
    );
endinterface

// File: rtl/exe_mul_seq_mul_iter_core.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle,
// ITER cycles per product, 33-bit add path so the carry out is never lost.
module mul_iter_core #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [XLEN-1:0]   mcand,
    input  logic [XLEN-1:0]   mplier,
    output logic              done,
    output logic [2*XLEN-1:0] prod
);
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    logic [XLEN-1:0]   mcand_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic [2*XLEN-1:0] acc_next;
    logic [CW-1:0]     cnt_reg;
    logic              run_reg;
    logic [XLEN:0]     sum;

    // Multiplier occupies the low half and drains out as the partial product shifts in.
    always_comb begin
        sum      = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
        acc_next = {sum, acc_reg[XLEN-1:1]};
    end

    assign done = run_reg && (cnt_reg == CW'(ITER - 1));
    assign prod = acc_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_reg <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            run_reg   <= 1'b0;
        end else if (abort) begin
            cnt_reg   <= '0;
            run_reg   <= 1'b0;
        end else if (start) begin
            mcand_reg <= mcand;
            acc_reg   <= {{XLEN{1'b0}}, mplier};
            cnt_reg   <= '0;
            run_reg   <= 1'b1;
        end else if (run_reg) begin
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_reg + CW'(1);
            if (done) begin
                run_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exe_mul_seq.sv
// Multi-cycle MUL/MULH sequencer for the execute stage: stalls the pipeline while
// the shift-add core runs, then presents one result-valid pulse to EX writeback.
module exe_mul_seq
    import exe_mul_seq_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = EXE_MUL_ITER
) (
    input logic          clk,
    input logic          rst_n,
    exe_mul_seq_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic              sign_reg;
    logic              want_high_reg;
    logic [XLEN-1:0]   res_reg;

    logic              is_mul;
    logic              accept;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic              core_done;
    logic [2*XLEN-1:0] core_prod;
    logic [2*XLEN-1:0] signed_prod;
    logic [XLEN-1:0]   final_res;
    logic              res_valid;

    assign is_mul = bus.op_valid && is_mul_op(bus.optype);
    assign accept = (state_reg == S_IDLE) && is_mul && !bus.flush;

    // Magnitudes go to an unsigned engine; 0x80000000 maps to itself, which is correct unsigned.
    assign mag1 = bus.data1[XLEN-1] ? -bus.data1 : bus.data1;
    assign mag2 = bus.data2[XLEN-1] ? -bus.data2 : bus.data2;

    mul_iter_core #(
        .XLEN (XLEN),
        .ITER (ITER)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept),
        .abort  (bus.flush),
        .mcand  (mag1),
        .mplier (mag2),
        .done   (core_done),
        .prod   (core_prod)
    );

    assign signed_prod = sign_reg ? -core_prod : core_prod;
    assign final_res   = want_high_reg ? signed_prod[2*XLEN-1:XLEN] : signed_prod[XLEN-1:0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = S_RUN;
            S_RUN:   if (core_done) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (bus.flush) begin
            state_next = S_IDLE;
        end
    end

    // A flush landing on the DONE cycle squashes the result.
    assign res_valid     = rst_n && (state_reg == S_DONE) && !bus.flush;
    assign bus.res_valid = res_valid;
    assign bus.res       = res_valid ? final_res : res_reg;
    assign bus.busy      = (state_reg == S_RUN);
    assign bus.stall     = rst_n && is_mul && (state_reg != S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            sign_reg      <= 1'b0;
            want_high_reg <= 1'b0;
            res_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                sign_reg      <= bus.data1[XLEN-1] ^ bus.data2[XLEN-1];
                want_high_reg <= (bus.optype == I_MULH);
            end
            if (res_valid) begin
                res_reg <= final_res;
            end
        end
    end

endmodule

// File: tb/tb_exe_mul_seq.sv
// Self-checking bench for exe_mul_seq: directed scenarios plus randomized
// MUL/MULH traffic compared against a plain 64-bit signed arithmetic model.
module tb_exe_mul_seq;
    import exe_mul_seq_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exe_mul_seq_if #(.XLEN(XLEN)) bus ();

    exe_mul_seq #(
        .XLEN (XLEN),
        .ITER (EXE_MUL_ITER)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] last_res = 32'h0;

    function automatic logic [31:0] ref_mul(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return (op == I_MULH) ? p[63:32] : p[31:0];
    endfunction

    task automatic drive_idle();
        bus.op_valid = 1'b0;
        bus.optype   = I_ADD;
        bus.data1    = '0;
        bus.data2    = '0;
        bus.flush    = 1'b0;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b1;
        bus.optype   = op;
        bus.data1    = a;
        bus.data2    = b;
        bus.flush    = 1'b0;
    endtask

    task automatic end_txn();
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    // Follows an issued multiply from its first EX cycle (c=0) up to the result pulse.
    task automatic wait_result(input logic [31:0] expv, input string name);
        int lat = -1;
        int stall_err = 0;
        int busy_err = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) begin
                lat = c;
                break;
            end
            if (bus.stall !== 1'b1) stall_err++;
            if (bus.busy !== (c >= 1)) busy_err++;
        end
        $display("txn %s: op=%0d a=%08h b=%08h res=%08h latency=%0d", name, bus.optype, bus.data1, bus.data2, bus.res, lat);
        vectors++;
        if (lat != 33) begin
            miscompares++;
            $display("FAIL %s latency: got %0d expected 33", name, lat);
        end
        vectors++;
        if (bus.res !== expv) begin
            miscompares++;
            $display("FAIL %s res: got %08h expected %08h", name, bus.res, expv);
        end
        vectors++;
        if (stall_err != 0 || busy_err != 0) begin
            miscompares++;
            $display("FAIL %s stall/busy profile: got %0d/%0d bad cycles expected 0/0", name, stall_err, busy_err);
        end
        vectors++;
        if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done-cycle stall/busy: got %b/%b expected 0/0", name, bus.stall, bus.busy);
        end
        last_res = expv;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("txn reset: stall=%b busy=%b res_valid=%b res=%08h", bus.stall, bus.busy, bus.res_valid, bus.res);
        vectors++;
        if (bus.stall !== 1'b0 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.res !== 32'h0) begin
            miscompares++;
            $display("FAIL reset outputs: got stall=%b busy=%b rv=%b res=%08h expected 0/0/0/0", bus.stall, bus.busy, bus.res_valid, bus.res);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post-reset idle: got busy=%b rv=%b expected 0/0", bus.busy, bus.res_valid);
        end
    endtask

    task automatic test_basic();
        issue(I_MUL, 32'd3, 32'd5);
        wait_result(32'h0000000F, "mul_3x5");
        end_txn();
    endtask

    task automatic test_signed();
        issue(I_MUL, 32'hFFFFFFFE, 32'd3);
        wait_result(32'hFFFFFFFA, "mul_m2x3");
        issue(I_MULH, 32'hFFFFFFFE, 32'd3);
        wait_result(32'hFFFFFFFF, "mulh_m2x3");
        issue(I_MULH, 32'h80000000, 32'h80000000);
        wait_result(32'h40000000, "mulh_min_min");
        issue(I_MUL, 32'h80000000, 32'h80000000);
        wait_result(32'h00000000, "mul_min_min");
        end_txn();
    endtask

    task automatic test_flush();
        int pulses = 0;
        int res_changes = 0;
        issue(I_MUL, 32'd7, 32'd9);
        for (int c = 0; c < 10; c++) @(negedge clk);
        @(posedge clk);
        #1;
        bus.flush    = 1'b1;
        bus.op_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b1 || bus.res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush T+10: got busy=%b rv=%b expected 1/0", bus.busy, bus.res_valid);
        end
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        $display("txn flush: busy=%b stall=%b res=%08h", bus.busy, bus.stall, bus.res);
        vectors++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
            miscompares++;
            $display("FAIL flush T+11: got busy=%b stall=%b expected 0/0", bus.busy, bus.stall);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0) pulses++;
            if (bus.res !== last_res) res_changes++;
        end
        vectors++;
        if (pulses != 0 || res_changes != 0) begin
            miscompares++;
            $display("FAIL flush aftermath: got %0d pulses %0d res changes expected 0/0", pulses, res_changes);
        end
    endtask

    task automatic test_reset_mid();
        issue(I_MUL, 32'd123, 32'd456);
        for (int c = 0; c < 20; c++) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        $display("txn reset_mid: busy=%b stall=%b rv=%b res=%08h", bus.busy, bus.stall, bus.res_valid, bus.res);
        vectors++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.res_valid !== 1'b0 || bus.res !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid outputs: got busy=%b stall=%b rv=%b res=%08h expected 0/0/0/0", bus.busy, bus.stall, bus.res_valid, bus.res);
        end
        last_res = 32'h0;
        rst_n = 1'b1;
        issue(I_MUL, 32'd6, 32'd7);
        wait_result(32'h0000002A, "mul_6x7_after_reset");
        end_txn();
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        issue(I_MUL, 32'd2, 32'd3);
        wait_result(32'd6, "b2b_mul_2x3");
        issue(I_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_result(32'h00000000, "b2b_mulh_m1xm1");
        issue(I_ADD, $urandom, $urandom);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.stall !== 1'b0 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        $display("txn add_between: bad_cycles=%0d", bad);
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL add_between: got %0d cycles with stall/rv/busy expected 0", bad);
        end
        issue(I_MUL, 32'd11, 32'd13);
        wait_result(32'd143, "mul_after_add");
        end_txn();
    endtask

    task automatic test_random();
        logic [31:0] corners [6];
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        corners[0] = 32'h00000000;
        corners[1] = 32'h00000001;
        corners[2] = 32'hFFFFFFFF;
        corners[3] = 32'h80000000;
        corners[4] = 32'h7FFFFFFF;
        corners[5] = 32'h80000001;
        for (int i = 0; i < 24; i++) begin
            op = ($urandom_range(0, 1) == 0) ? I_MUL : I_MULH;
            a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            issue(op, a, b);
            wait_result(ref_mul(op, a, b), $sformatf("rand%0d", i));
        end
        end_txn();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        test_reset();
        test_basic();
        test_signed();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exe_mul_seq.md
Name: exe_mul_seq

Overview:
Multi-cycle multiply sequencer for the execute stage. It takes MUL/MULH work off the single-cycle ALU path and runs it on an iterative shift-add engine. It stalls the pipeline while the engine runs, then hands back one result-valid pulse for the EX writeback mux. Pipeline flushes (taken branch/JAL clear) abort it.

Parameters:
XLEN, 32, operand/result width
ITER, 32, engine iterations per multiply; must equal XLEN

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
optype  in  5  EX-stage operation code, same encoding as decoder output
op_valid  in  1  EX stage holds a live instruction
data1  in  XLEN  rs1 operand
data2  in  XLEN  rs2 operand
flush  in  1  pipeline clear; aborts in-flight multiply
stall  out  1  hold IF/ID/EX registers this cycle
busy  out  1  engine running (state RUN)
res_valid  out  1  one-cycle pulse: res is the final product
res  out  XLEN  MUL low word or MULH signed high word

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n).
- Reset values: state IDLE, stall 0, busy 0, res_valid 0, res 0, internal product/counter 0. Reset mid-operation discards the product and returns to IDLE.
- is_mul = op_valid & (optype == I_MUL | optype == I_MULH). Any other optype is ignored; stall stays 0 for it.
- States and transitions:
  - IDLE: if is_mul & ~flush, latch |data1|, |data2|, result sign (data1[31]^data2[31]), want_high (optype == I_MULH), counter=0, then go to RUN.
  - RUN: each cycle, if multiplier LSB is 1, add multiplicand to the upper 33 bits of the 64-bit accumulator, then shift right 1. Counter increments. When counter == ITER-1, go to DONE.
  - DONE: apply the sign. If the sign is negative, take the two's complement of the 64-bit magnitude. Set res = want_high ? prod[63:32] : prod[31:0] and pulse res_valid=1 for this single cycle. Return to IDLE.
- stall (combinational) = is_mul & (state != DONE). It is high from the first cycle the instruction sits in EX up to and including the last RUN cycle; it is 0 in DONE, so the pipeline advances in the same cycle res is registered.
- Latency: instruction enters EX at cycle T. Accept is at T, RUN covers T+1..T+32, DONE is at T+33 and res_valid is seen at T+33. Total 34 EX cycles.
- The upstream stage holds optype/data1/data2 stable while stall=1. Operands are sampled only at accept.
- flush in any state: go to IDLE next cycle; res_valid stays 0; res keeps its old value. flush with DONE in the same cycle: flush wins and res_valid is 0.
- Back-to-back multiplies: the DONE→IDLE cycle accepts the next instruction. A second MUL entering EX at T+34 gets res_valid at T+67.
- Signed arithmetic: operands are treated as two's complement (MULH = signed×signed). |0x80000000| = 0x80000000 as an unsigned 32-bit value; the 33-bit add path keeps the carry.
- res_valid never asserts in IDLE or RUN.

Decomposition:
- Shared opcode header (existing optype defines): I_MUL and I_MULH come from it. Add EXE_MUL_ITER=32 there.
- Local state encoding (IDLE/RUN/DONE) is a localparam inside the module.
- One sub-module: mul_iter_core. It holds the accumulator, counter and shift-add datapath, with start/done. exe_mul_seq keeps the FSM, sign handling, stall and flush.

Test Plan:
1. MUL data1=3, data2=5, op_valid held: stall=1 for cycles T..T+32, res_valid at T+33, res=0x0000000F.
2. MUL -2 (0xFFFFFFFE) × 3 → res=0xFFFFFFFA. Repeat as MULH → res=0xFFFFFFFF.
3. MULH 0x80000000 × 0x80000000 → res=0x40000000. MUL with the same operands → res=0x00000000.
4. Accept MUL 7×9; assert flush at T+10 for one cycle → busy=0 at T+11, res_valid never pulses, stall=0 once op_valid drops.
5. Drive rst_n=0 at T+20 of a running MUL → next edge: state IDLE, busy/stall/res_valid/res all 0. A subsequent MUL 6×7 → res=0x0000002A.
6. Back-to-back MUL 2×3 then MULH 0xFFFFFFFF×0xFFFFFFFF (-1×-1): res_valid at T+33 (res=6) and T+67 (res=0x00000000). An ADD issued between them → stall=0 and no res_valid.
